// File: rtl/dm_pkg.sv
// Shared definitions for the byte-enabled data memory: access-size codes,
// FSM state encoding and the alignment rule.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITST = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

    // Illegal size code counts as an error just like a misaligned access
    function automatic logic dm_bad_access(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Lane formatting for data_mem_be: extracts and extends load data from a
// memory word, and merges right-aligned store data into the addressed lanes.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] ldata,
    output logic [31:0] merged
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte  = rword[{lane, 3'b000} +: 8];
        rhalf  = rword[{lane[1], 4'b0000} +: 16];
        ldata  = '0;
        merged = rword;
        case (size)
            SZ_B: begin
                ldata = {{24{sign_ext & rbyte[7]}}, rbyte};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ldata = {{16{sign_ext & rhalf[15]}}, rhalf};
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_W: begin
                ldata  = rword;
                merged = wdata;
            end
            default: begin
                ldata  = '0;
                merged = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_be.sv
// Byte-enabled data memory with WAIT wait states and a valid/ready response.
// Optional store trace printing is enabled with the DM_TRACE_EN macro.
module data_mem_be
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    dm_state_e   state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic        q_we, q_signed;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata, q_pc;

    logic        accept, enter_resp;
    logic        cur_we, cur_signed, cur_err;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [31:0] ldata, merged;
    logic        unused_bits;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (WAIT == 0) ? RESP : WAITST;
            WAITST:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        rsp_valid  = (state == RESP);
        accept     = req_valid && req_ready;
        enter_resp = (accept && (WAIT == 0)) || ((state == WAITST) && (cnt == 4'd0));
    end

    // With no wait states the access completes on the accepting edge, so the
    // live request fields are used until the captured copy is valid.
    always_comb begin
        if (state == IDLE) begin
            cur_we     = req_we;
            cur_size   = req_size;
            cur_signed = req_signed;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = q_we;
            cur_size   = q_size;
            cur_signed = q_signed;
            cur_addr   = q_addr;
            cur_wdata  = q_wdata;
        end
        idx     = cur_addr[AW+1:2];
        cur_err = dm_bad_access(cur_size, cur_addr[1:0]);
    end

    dm_lane_fmt u_lane_fmt (
        .size     (cur_size),
        .sign_ext (cur_signed),
        .lane     (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .rword    (mem[idx]),
        .ldata    (ldata),
        .merged   (merged)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt       <= '0;
            q_we      <= 1'b0;
            q_size    <= '0;
            q_signed  <= 1'b0;
            q_addr    <= '0;
            q_wdata   <= '0;
            q_pc      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                q_we     <= req_we;
                q_size   <= req_size;
                q_signed <= req_signed;
                q_addr   <= req_addr;
                q_wdata  <= req_wdata;
                q_pc     <= req_pc;
                cnt      <= WAIT_LOAD;
            end else if ((state == WAITST) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_we) ? 32'd0 : ldata;
                if (cur_we && !cur_err) mem[idx] <= merged;
            end
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] cur_pc;
    assign cur_pc = (state == IDLE) ? req_pc : q_pc;

    always_ff @(posedge Clk) begin
        if (!Reset && enter_resp && cur_we && !cur_err)
            $display("%0t@%08h: *%08h <= %08h", $time, cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
`endif

    assign unused_bits = ^{q_pc, cur_addr[31:AW+2]};

endmodule
